// File: rtl/udma_sdio_cfg_initiator.sv
// udma_sdio_cfg_initiator
// Master on the uDMA peripheral cfg bus that runs one SD command on the SDIO
// register block: programs CMD_OP, CMD_ARG, DATA_SETUP and START, waits for
// end-of-transfer (or error), then reads RSP0..RSP3 into a 128-bit response.
//
// Optional feature macro: SDIO_CFG_INIT_TIMEOUT_EN
//   defined   -> WAIT_EOT is bounded by a TIMEOUT_W-bit watchdog; expiry ends
//                the command with rsp_err_o=1 and rsp_data_o=0 (the SDIO block
//                itself is not touched).
//   undefined -> WAIT_EOT waits indefinitely; TIMEOUT_* parameters are unused.

module udma_sdio_cfg_initiator #(
  parameter int unsigned                TIMEOUT_W      = 20,
  parameter logic [TIMEOUT_W-1:0]       TIMEOUT_CYCLES = 20'hFFFFF
) (
  input  logic          clk_i,
  input  logic          rstn_i,

  // command request
  input  logic          req_valid_i,
  output logic          req_ready_o,
  input  logic [5:0]    req_cmd_op_i,
  input  logic [2:0]    req_rsp_type_i,
  input  logic [31:0]   req_cmd_arg_i,
  input  logic [31:0]   req_data_setup_i,

  // SDIO core status pulses
  input  logic          sdio_eot_i,
  input  logic          sdio_err_i,

  // response
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [127:0]  rsp_data_o,
  output logic          rsp_err_o,

  // cfg bus master
  output logic          cfg_valid_o,
  output logic          cfg_rwn_o,
  output logic [4:0]    cfg_addr_o,
  output logic [31:0]   cfg_data_o,
  input  logic [31:0]   cfg_data_i,
  input  logic          cfg_ready_i,

  output logic          busy_o
);

  // SDIO register word addresses
  localparam logic [4:0] ADDR_CMD_OP   = 5'h08;
  localparam logic [4:0] ADDR_CMD_ARG  = 5'h09;
  localparam logic [4:0] ADDR_DATA_SET = 5'h0A;
  localparam logic [4:0] ADDR_START    = 5'h0B;
  localparam logic [4:0] ADDR_RSP0     = 5'h0C;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_OP,
    S_WR_ARG,
    S_WR_SETUP,
    S_WR_START,
    S_WAIT_EOT,
    S_RD_RSP,
    S_RESP
  } state_e;

  state_e         state_q, state_d;

  logic [5:0]     cmd_op_q,     cmd_op_d;
  logic [2:0]     rsp_type_q,   rsp_type_d;
  logic [31:0]    cmd_arg_q,    cmd_arg_d;
  logic [31:0]    data_setup_q, data_setup_d;
  logic [1:0]     idx_q,        idx_d;
  logic [127:0]   rsp_data_q,   rsp_data_d;
  logic           rsp_err_q,    rsp_err_d;
  logic           eot_q;
  logic           err_q;
  // Keeps req_ready_o low while reset is applied (IDLE alone would raise it).
  logic           ready_en_q;

  logic           req_fire;
  logic           eot_seen;
  logic           err_seen;

  assign req_fire = req_valid_i & req_ready_o;
  // Live pulse OR sticky copy, so an eot in the last WAIT_EOT-entry cycle is
  // acted on in the same cycle (keeps eot->read latency at one cycle).
  assign eot_seen = eot_q | sdio_eot_i;
  assign err_seen = err_q | sdio_err_i;

`ifdef SDIO_CFG_INIT_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_ONE = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  logic [TIMEOUT_W-1:0] to_cnt_q;
  logic                 to_expired;

  // Watchdog: zero outside WAIT_EOT, counts every WAIT_EOT cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      to_cnt_q <= '0;
    end else if (state_q != S_WAIT_EOT) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + CNT_ONE;
    end
  end

  // Expires in the TIMEOUT_CYCLES-th WAIT_EOT cycle, so RESP follows exactly
  // TIMEOUT_CYCLES cycles of waiting.
  assign to_expired = ((to_cnt_q + CNT_ONE) == TIMEOUT_CYCLES);
`else
  logic unused_timeout_params;
  assign unused_timeout_params = ^{TIMEOUT_CYCLES, TIMEOUT_W};
`endif

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      cmd_op_q     <= '0;
      rsp_type_q   <= '0;
      cmd_arg_q    <= '0;
      data_setup_q <= '0;
      idx_q        <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      ready_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_op_q     <= cmd_op_d;
      rsp_type_q   <= rsp_type_d;
      cmd_arg_q    <= cmd_arg_d;
      data_setup_q <= data_setup_d;
      idx_q        <= idx_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      ready_en_q   <= 1'b1;
    end
  end

  // Sticky eot/err: cleared on request acceptance, then collect pulses from
  // the following cycle on so a pulse during the register writes is kept.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      eot_q <= 1'b0;
      err_q <= 1'b0;
    end else if (req_fire) begin
      eot_q <= 1'b0;
      err_q <= 1'b0;
    end else if (state_q != S_IDLE) begin
      eot_q <= eot_q | sdio_eot_i;
      err_q <= err_q | sdio_err_i;
    end
  end

  // Next-state logic and cfg bus drive; cfg outputs depend only on state and
  // captured registers, so they hold steady while the bus stalls.
  always_comb begin
    state_d      = state_q;
    cmd_op_d     = cmd_op_q;
    rsp_type_d   = rsp_type_q;
    cmd_arg_d    = cmd_arg_q;
    data_setup_d = data_setup_q;
    idx_d        = idx_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cfg_valid_o  = 1'b0;
    cfg_rwn_o    = 1'b0;
    cfg_addr_o   = 5'h00;
    cfg_data_o   = 32'h0;

    unique case (state_q)
      S_IDLE: begin
        if (req_fire) begin
          cmd_op_d     = req_cmd_op_i;
          rsp_type_d   = req_rsp_type_i;
          cmd_arg_d    = req_cmd_arg_i;
          data_setup_d = req_data_setup_i;
          idx_d        = 2'd0;
          rsp_data_d   = '0;
          rsp_err_d    = 1'b0;
          state_d      = S_WR_OP;
        end
      end

      S_WR_OP: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_CMD_OP;
        cfg_data_o  = {21'h0, rsp_type_q, 2'b00, cmd_op_q};
        if (cfg_ready_i) state_d = S_WR_ARG;
      end

      S_WR_ARG: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_CMD_ARG;
        cfg_data_o  = cmd_arg_q;
        if (cfg_ready_i) state_d = S_WR_SETUP;
      end

      S_WR_SETUP: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_DATA_SET;
        cfg_data_o  = data_setup_q;
        if (cfg_ready_i) state_d = S_WR_START;
      end

      S_WR_START: begin
        cfg_valid_o = 1'b1;
        cfg_addr_o  = ADDR_START;
        cfg_data_o  = 32'h1;
        if (cfg_ready_i) state_d = S_WAIT_EOT;
      end

      S_WAIT_EOT: begin
        // Error has priority over a simultaneous end-of-transfer.
        if (err_seen) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end else if (eot_seen) begin
          if (rsp_type_q != 3'd0) begin
            idx_d   = 2'd0;
            state_d = S_RD_RSP;
          end else begin
            rsp_data_d = '0;
            state_d    = S_RESP;
          end
        end
`ifdef SDIO_CFG_INIT_TIMEOUT_EN
        else if (to_expired) begin
          rsp_err_d  = 1'b1;
          rsp_data_d = '0;
          state_d    = S_RESP;
        end
`endif
      end

      S_RD_RSP: begin
        cfg_valid_o = 1'b1;
        cfg_rwn_o   = 1'b1;
        cfg_addr_o  = ADDR_RSP0 + {3'b000, idx_q};
        if (cfg_ready_i) begin
          rsp_data_d[{idx_q, 5'b00000} +: 32] = cfg_data_i;
          if (idx_q == 2'd3) begin
            state_d = S_RESP;
          end else begin
            idx_d = idx_q + 2'd1;
          end
        end
      end

      S_RESP: begin
        if (rsp_ready_i) state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign req_ready_o = (state_q == S_IDLE) & ready_en_q;
  assign busy_o      = (state_q != S_IDLE);
  assign rsp_valid_o = (state_q == S_RESP);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_udma_sdio_cfg_initiator.sv
// Testbench for udma_sdio_cfg_initiator: table of command vectors with a
// cfg-bus / response scoreboard, plus hand-written reset-abort sequence.
// With SDIO_CFG_INIT_TIMEOUT_EN defined, a watchdog vector is added.

module tb_udma_sdio_cfg_initiator;

  localparam int TO_CYC = 50;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [5:0]    req_cmd_op_i = '0;
  logic [2:0]    req_rsp_type_i = '0;
  logic [31:0]   req_cmd_arg_i = '0;
  logic [31:0]   req_data_setup_i = '0;
  logic          sdio_eot_i = 1'b0;
  logic          sdio_err_i = 1'b0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b0;
  logic [127:0]  rsp_data_o;
  logic          rsp_err_o;
  logic          cfg_valid_o;
  logic          cfg_rwn_o;
  logic [4:0]    cfg_addr_o;
  logic [31:0]   cfg_data_o;
  logic [31:0]   cfg_data_i;
  logic          cfg_ready_i = 1'b1;
  logic          busy_o;

  udma_sdio_cfg_initiator #(
    .TIMEOUT_W      (20),
    .TIMEOUT_CYCLES (20'd50)
  ) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_cmd_op_i     (req_cmd_op_i),
    .req_rsp_type_i   (req_rsp_type_i),
    .req_cmd_arg_i    (req_cmd_arg_i),
    .req_data_setup_i (req_data_setup_i),
    .sdio_eot_i       (sdio_eot_i),
    .sdio_err_i       (sdio_err_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_ready_i      (rsp_ready_i),
    .rsp_data_o       (rsp_data_o),
    .rsp_err_o        (rsp_err_o),
    .cfg_valid_o      (cfg_valid_o),
    .cfg_rwn_o        (cfg_rwn_o),
    .cfg_addr_o       (cfg_addr_o),
    .cfg_data_o       (cfg_data_o),
    .cfg_data_i       (cfg_data_i),
    .cfg_ready_i      (cfg_ready_i),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  int errors = 0;
  int checks = 0;
  int stall_cfg = 0;
  logic [31:0] rd_base = 32'h0;

  // Register-file responder: RSPn returns rd_base + n.
  assign cfg_data_i = (cfg_valid_o && cfg_rwn_o) ? (rd_base + 32'(cfg_addr_o) - 32'd12) : 32'hBAD0_BAD0;

  typedef struct {
    logic [4:0]  addr;
    logic        rwn;
    logic [31:0] data;
    int          cyc;
  } exp_cfg_t;

  typedef struct {
    logic [127:0] data;
    logic         err;
    int           cyc;
  } exp_rsp_t;

  typedef struct {
    logic [5:0]  op;
    logic [2:0]  rt;
    logic [31:0] arg;
    logic [31:0] setup;
    int          stall;
    int          n;      // cycle of the eot/err pulse, relative to acceptance
    bit          eot;
    bit          err;
    logic [31:0] base;
  } vec_t;

  exp_cfg_t exp_cfg[$];
  exp_rsp_t exp_rsp[$];
  exp_rsp_t cur_rsp;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // cfg_ready_i driver: stall each transfer for stall_cfg cycles
  initial begin : ready_drv
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clk_i);
      #1;
      if (stall_cfg == 0) begin
        cfg_ready_i = 1'b1;
        wcnt = 0;
      end else if (!cfg_valid_o) begin
        cfg_ready_i = 1'b0;
        wcnt = 0;
      end else if (wcnt < stall_cfg) begin
        cfg_ready_i = 1'b0;
        wcnt++;
      end else begin
        cfg_ready_i = 1'b1;
        wcnt = 0;
      end
    end
  end

  // Monitor: pops expected cfg transfers and responses as the DUT produces them
  initial begin : monitor
    bit hold_v, rsp_seen;
    logic [4:0] h_addr;
    logic [31:0] h_data;
    logic h_rwn;
    exp_cfg_t e;
    hold_v = 0;
    rsp_seen = 0;
    h_addr = '0; h_data = '0; h_rwn = 0;
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        hold_v = 0;
        rsp_seen = 0;
      end else begin
        if (cfg_valid_o) begin
          if (hold_v) begin
            chk("cfg_hold_addr", cfg_addr_o, h_addr);
            chk("cfg_hold_data", cfg_data_o, h_data);
            chk("cfg_hold_rwn", cfg_rwn_o, h_rwn);
          end
          if (cfg_ready_i) begin
            hold_v = 0;
            if (exp_cfg.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL cfg_unexpected: got addr %0h rwn %0b, expected no transfer (cycle %0d)",
                       cfg_addr_o, cfg_rwn_o, cyc);
            end else begin
              e = exp_cfg.pop_front();
              chk("cfg_addr", cfg_addr_o, e.addr);
              chk("cfg_rwn", cfg_rwn_o, e.rwn);
              if (!e.rwn) chk("cfg_wdata", cfg_data_o, e.data);
              chk("cfg_cycle", cyc, e.cyc);
            end
          end else begin
            hold_v = 1;
            h_addr = cfg_addr_o;
            h_data = cfg_data_o;
            h_rwn  = cfg_rwn_o;
          end
        end else begin
          hold_v = 0;
        end

        if (rsp_valid_o) begin
          if (!rsp_seen) begin
            rsp_seen = 1;
            if (exp_rsp.size() == 0) begin
              errors++;
              checks++;
              $display("FAIL rsp_unexpected: got data %0h err %0b, expected no response", rsp_data_o, rsp_err_o);
              cur_rsp.data = rsp_data_o;
              cur_rsp.err  = rsp_err_o;
            end else begin
              cur_rsp = exp_rsp.pop_front();
              chk("rsp_data", rsp_data_o, cur_rsp.data);
              chk("rsp_err", rsp_err_o, cur_rsp.err);
              chk("rsp_cycle", cyc, cur_rsp.cyc);
            end
          end else begin
            chk("rsp_data_stable", rsp_data_o, cur_rsp.data);
            chk("rsp_err_stable", rsp_err_o, cur_rsp.err);
          end
        end else begin
          rsp_seen = 0;
        end
      end
    end
  end

  // Drive one request (pushing its four expected writes) once IDLE; returns
  // the acceptance cycle and leaves req_valid_i low afterwards.
  task automatic issue(input vec_t v, output int c0);
    int k;
    exp_cfg_t e;
    k = 0;
    @(posedge clk_i); #1;
    while (!req_ready_o && k < 50) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("req_ready_idle", req_ready_o, 1'b1);
    stall_cfg = v.stall;
    rd_base   = v.base;
    c0 = cyc;
    req_valid_i      = 1'b1;
    req_cmd_op_i     = v.op;
    req_rsp_type_i   = v.rt;
    req_cmd_arg_i    = v.arg;
    req_data_setup_i = v.setup;
    for (int i = 0; i < 4; i++) begin
      e.addr = 5'h08 + 5'(i);
      e.rwn  = 1'b0;
      case (i)
        0:       e.data = {21'h0, v.rt, 2'b00, v.op};
        1:       e.data = v.arg;
        2:       e.data = v.setup;
        default: e.data = 32'h1;
      endcase
      e.cyc = c0 + 1 + i * (v.stall + 1) + v.stall;
      exp_cfg.push_back(e);
    end
    @(posedge clk_i); #1;
    req_valid_i      = 1'b0;
    req_cmd_op_i     = 6'($urandom);
    req_rsp_type_i   = 3'($urandom);
    req_cmd_arg_i    = $urandom;
    req_data_setup_i = $urandom;
  endtask

  task automatic run_vec(input vec_t v);
    int c0, entry, eff, rc, k;
    bit reads;
    exp_cfg_t e;
    exp_rsp_t r;
    issue(v, c0);
    entry = c0 + 1 + 4 * (v.stall + 1);
    reads = v.eot && !v.err && (v.rt != 3'd0);
    if (v.eot || v.err) begin
      eff = (c0 + v.n > entry) ? c0 + v.n : entry;
      rc  = eff + 1 + (reads ? 4 * (v.stall + 1) : 0);
    end else begin
      eff = entry;
      rc  = entry + TO_CYC;
    end
    for (int j = 0; j < 4; j++) begin
      if (reads) begin
        e.addr = 5'h0C + 5'(j);
        e.rwn  = 1'b1;
        e.data = '0;
        e.cyc  = eff + 1 + j * (v.stall + 1) + v.stall;
        exp_cfg.push_back(e);
      end
    end
    r.data = reads ? {v.base + 32'd3, v.base + 32'd2, v.base + 32'd1, v.base} : 128'h0;
    r.err  = v.err || !v.eot;
    r.cyc  = rc;
    exp_rsp.push_back(r);

    if (v.eot || v.err) begin
      k = 0;
      while (cyc < c0 + v.n && k < 200) begin
        @(posedge clk_i); #1;
        k++;
      end
      sdio_eot_i = v.eot;
      sdio_err_i = v.err;
      @(posedge clk_i); #1;
      sdio_eot_i = 1'b0;
      sdio_err_i = 1'b0;
    end

    k = 0;
    while (!rsp_valid_o && k < 500) begin
      @(posedge clk_i); #1;
      k++;
    end
    if (!rsp_valid_o) begin
      errors++;
      checks++;
      $display("FAIL rsp_wait: got rsp_valid_o=0, expected 1 within 500 cycles");
    end
    // A competing request during RESP must not be accepted.
    req_valid_i = 1'b1;
    chk("req_ready_in_resp", req_ready_o, 1'b0);
    chk("busy_in_resp", busy_o, 1'b1);
    @(posedge clk_i); #1;
    chk("req_ready_in_resp2", req_ready_o, 1'b0);
    chk("rsp_valid_held", rsp_valid_o, 1'b1);
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    rsp_ready_i = 1'b0;
    chk("rsp_valid_after_hs", rsp_valid_o, 1'b0);
    chk("busy_after_hs", busy_o, 1'b0);
    $display("vec op=%0d rt=%0d stall=%0d eot=%0b err=%0b accepted@%0d rsp@%0d data=%0h err=%0b",
             v.op, v.rt, v.stall, v.eot, v.err, c0, rc, r.data, r.err);
  endtask

`ifdef SDIO_CFG_INIT_TIMEOUT_EN
  localparam int NV = 8;
`else
  localparam int NV = 7;
`endif

  vec_t vecs[NV];

  initial begin : main
    vec_t v;
    int c0, entry, k;
    //          op     rt    arg            setup          stall n   eot err base
    vecs[0] = '{6'd17, 3'd1, 32'h0000_0200, 32'h0200_0101, 0,    10, 1,  0,  32'h0000_00A0};
    vecs[1] = '{6'h2A, 3'd2, 32'hDEAD_BEEF, 32'h03FF_FF07, 3,    20, 1,  0,  32'h1000_0000};
    vecs[2] = '{6'd0,  3'd0, 32'h0000_0000, 32'h0000_0000, 0,    7,  1,  0,  32'h2222_0000};
    vecs[3] = '{6'd63, 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0,    5,  1,  1,  32'h3333_0000};
    vecs[4] = '{6'd5,  3'd3, 32'h1234_5678, 32'h0000_0000, 1,    15, 0,  1,  32'h4444_0000};
    vecs[5] = '{6'd8,  3'd1, 32'h0000_01AA, 32'h0010_0003, 0,    5,  1,  0,  32'h5555_0000};
    vecs[6] = '{6'd55, 3'd1, 32'h8000_0001, 32'h0001_0201, 0,    4,  1,  0,  32'h6666_0000};
`ifdef SDIO_CFG_INIT_TIMEOUT_EN
    vecs[7] = '{6'd12, 3'd1, 32'h0000_0777, 32'h0000_0000, 0,    0,  0,  0,  32'h7777_0000};
`endif

    // Reset state
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_req_ready", req_ready_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_cfg_valid", cfg_valid_o, 1'b0);
    chk("rst_rsp", {rsp_valid_o, rsp_err_o, rsp_data_o}, 130'h0);
    chk("rst_cfg_bus", {cfg_rwn_o, cfg_addr_o, cfg_data_o}, 38'h0);
    rstn_i = 1'b1;

    for (int i = 0; i < NV; i++) run_vec(vecs[i]);

    // Reset while waiting for end-of-transfer
    v = vecs[0];
    issue(v, c0);
    entry = c0 + 5;
    k = 0;
    while (cyc < entry + 3 && k < 100) begin
      @(posedge clk_i); #1;
      k++;
    end
    chk("pre_abort_busy", busy_o, 1'b1);
    rstn_i = 1'b0;
    #1;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_req_ready", req_ready_o, 1'b0);
    chk("abort_outputs", {rsp_valid_o, rsp_err_o, rsp_data_o, cfg_valid_o, cfg_rwn_o, cfg_addr_o, cfg_data_o}, 169'h0);
    chk("abort_writes_done", exp_cfg.size(), 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("abort_cfg_valid_held", cfg_valid_o, 1'b0);
    rstn_i = 1'b1;
    run_vec(vecs[5]);

    repeat (3) @(posedge clk_i);
    #1;
    chk("sb_cfg_drained", exp_cfg.size(), 0);
    chk("sb_rsp_drained", exp_rsp.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion, expected finish before 200000 cycles");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/udma_sdio_cfg_initiator.md
Name: udma_sdio_cfg_initiator

Overview:
Master side of the uDMA peripheral cfg bus (cfg_valid/cfg_rwn/cfg_addr/cfg_data/cfg_ready) for driving the SDIO register block. Accepts one SD command descriptor over a valid/ready request port and programs CMD_OP, CMD_ARG, DATA_SETUP and START in sequence. It then waits for end-of-transfer and reads back RSP0..RSP3, returning a 128-bit response. Sits between a small control core or boot FSM and the SDIO peripheral cfg port.

Parameters:
TIMEOUT_W, 20, width of the end-of-transfer watchdog counter (used only with the optional feature).
TIMEOUT_CYCLES, 20'hFFFFF, cycles spent in WAIT_EOT before abort (optional feature only).

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_valid_i  in  1  command request valid
req_ready_o  out  1  request accepted this cycle; high only in IDLE
req_cmd_op_i  in  6  SD command index
req_rsp_type_i  in  3  response type; 0 = no response
req_cmd_arg_i  in  32  command argument
req_data_setup_i  in  32  raw DATA_SETUP word: en[0], rwn[1], quad[2], block_num[15:8], block_size[25:16]
sdio_eot_i  in  1  single-cycle end-of-transfer pulse from the SDIO core
sdio_err_i  in  1  single-cycle error pulse from the SDIO core
rsp_valid_o  out  1  response available
rsp_ready_i  in  1  response consumed
rsp_data_o  out  128  {RSP3,RSP2,RSP1,RSP0}
rsp_err_o  out  1  error or timeout flag for this command
cfg_valid_o  out  1  cfg bus request
cfg_rwn_o  out  1  1 = read, 0 = write
cfg_addr_o  out  5  word address
cfg_data_o  out  32  write data
cfg_data_i  in  32  read data; valid in the cycle cfg_valid_o & cfg_ready_i & cfg_rwn_o
cfg_ready_i  in  1  cfg bus accept
busy_o  out  1  high in every state except IDLE

Behaviour:
- Reset: all outputs 0; FSM in IDLE; internal response, error and sticky registers cleared. Reset mid-operation aborts immediately with no further cfg cycles.
- Request handshake: transfer on req_valid_i & req_ready_o. On acceptance, capture all req_* fields and clear the sticky eot/err flags.
- States and cfg cycles:
  - WR_OP: write addr 5'h08, data {21'h0, rsp_type, 2'b00, op}.
  - WR_ARG: write addr 5'h09, data = arg.
  - WR_SETUP: write addr 5'h0A, data = data_setup.
  - WR_START: write addr 5'h0B, data 32'h1.
  - WAIT_EOT: no cfg cycles.
  - RD_RSP: reads addr 5'h0C + idx, idx 0..3.
  - RESP: present response.
- cfg handshake:
  - Each write or read state asserts cfg_valid_o and advances only on cfg_ready_i.
  - addr, data and rwn are held stable while cfg_valid_o & ~cfg_ready_i.
  - cfg_valid_o is combinational from state, so back-to-back accepts are allowed.
- Read capture: cfg_data_i is captured into slot idx of rsp_data in the accepting cycle. idx 3 accepted -> RESP.
- Sticky flags: sdio_eot_i and sdio_err_i are latched from the cycle after request acceptance onward, so a pulse arriving during WR_START is not lost.
- WAIT_EOT exit:
  - err sticky set -> RESP, with rsp_err_o=1 and rsp_data_o=0.
  - else eot sticky set and rsp_type!=0 -> RD_RSP, idx=0.
  - else eot sticky set and rsp_type==0 -> RESP, with rsp_data_o=0 and rsp_err_o=0.
  - eot and err in the same cycle: err wins.
- RESP: rsp_valid_o=1; rsp_data_o and rsp_err_o are stable until rsp_valid_o & rsp_ready_i, then -> IDLE. rsp_valid_o deasserts the following cycle.
- Latency (cfg_ready_i tied high, request accepted at cycle 0):
  - Writes occur in cycles 1-4; WAIT_EOT is entered at cycle 5.
  - For eot at cycle N (N>=5): reads at N+1..N+4, rsp_valid_o at N+5.
  - No-response command: rsp_valid_o at N+1.
- New requests are not accepted until the response handshake completes. req_ready_o=0 outside IDLE.

Optional Feature:
SDIO_CFG_INIT_TIMEOUT_EN
- Defined: a TIMEOUT_W counter clears on entry to WAIT_EOT and increments each WAIT_EOT cycle. On reaching TIMEOUT_CYCLES without eot/err -> RESP with rsp_err_o=1 and rsp_data_o=0. The block does not write the SDIO block to abort it.
- Undefined: no counter; WAIT_EOT waits indefinitely, and the TIMEOUT_* parameters are unused.

Test Plan:
- Basic command, cfg_ready_i=1: op=6'd17, rsp_type=1, arg=32'h0000_0200, setup=32'h0200_0101.
  - Writes appear in order: (08, 32'h0000_0111), (09, 32'h200), (0A, 32'h0200_0101), (0B, 1).
  - eot at cycle 10 -> reads 0C..0F; responder returns 32'hA0..A3 -> rsp_data_o = {A3,A2,A1,A0}, rsp_valid_o at cycle 15.
- Backpressure: cfg_ready_i low for 3 cycles on each transfer -> addr/data held constant while stalled; each write appears exactly once; sequence unchanged.
- No-response command: rsp_type=0, eot pulse -> zero cfg reads; rsp_valid_o the cycle after eot; rsp_data_o=0; rsp_err_o=0.
- Error path:
  - sdio_err_i and sdio_eot_i in the same cycle -> no reads; rsp_err_o=1.
  - A second request held during RESP -> req_ready_o=0 until rsp_ready_i completes the handshake.
- Early eot: eot pulse in the WR_START accept cycle -> sticky flag captured; RD_RSP starts the cycle after WAIT_EOT entry.
- Timeout, macro defined with TIMEOUT_CYCLES=20'd50: no eot -> RESP with rsp_err_o=1 after 50 WAIT_EOT cycles. Reset asserted mid-WAIT_EOT -> all outputs 0; next request proceeds normally.
